// File: rtl/buffer_to_mem_wr_engine.sv
// Drains a FWFT line buffer into host memory as CCI-P C1 write requests, using aligned bursts and an
// outstanding-line credit limit. Define WR_ENGINE_PERF_EN to add cycle/stall performance counters.
module buffer_to_mem_wr_engine #(
  parameter int ADDR_W          = 42,
  parameter int LEN_W           = 32,
  parameter int DATA_W          = 512,
  parameter int BURST_LINES     = 4,
  parameter int MAX_OUTSTANDING = 64,
  parameter int BUF_CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [LEN_W-1:0]     num_lines,
  output logic                 done,
  output logic                 err_rsp,
  input  logic [DATA_W-1:0]    buf_rd_data,
  input  logic [BUF_CNT_W-1:0] buf_count,
  output logic                 buf_rd_en,
  input  logic                 tx_almfull,
  output logic                 tx_valid,
  output logic                 tx_sop,
  output logic [ADDR_W-1:0]    tx_addr,
  output logic [1:0]           tx_cl_len,
  output logic [DATA_W-1:0]    tx_data,
  input  logic                 rx_wr_rsp_valid,
  input  logic                 rx_wr_rsp_packed,
  input  logic [1:0]           rx_wr_rsp_cl_num,
  output logic [1:0]           dbg_state
`ifdef WR_ENGINE_PERF_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_stall_almfull,
  output logic [31:0]          perf_stall_credit,
  output logic [31:0]          perf_stall_empty
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_e;

  localparam logic [LEN_W-1:0]     BURST_LEN  = LEN_W'(BURST_LINES);
  localparam logic [LEN_W-1:0]     MAX_OUT    = LEN_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0]    ALIGN_MASK = ADDR_W'(BURST_LINES - 1);
  localparam logic [BUF_CNT_W-1:0] BURST_BUF  = BUF_CNT_W'(BURST_LINES);
  localparam logic [1:0]           BURST_CL   = 2'(BURST_LINES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [ADDR_W-1:0]   burst_addr_q, burst_addr_d;
  logic [LEN_W-1:0]    num_lines_q, num_lines_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [LEN_W-1:0]    acked_q, acked_d;
  logic [LEN_W-1:0]    outstanding_q, outstanding_d;
  logic [1:0]          burst_left_q, burst_left_d;
  logic [1:0]          burst_cl_q, burst_cl_d;
  logic                err_q, err_d;
  logic                tx_valid_q, tx_valid_d;
  logic                tx_sop_q, tx_sop_d;
  logic [ADDR_W-1:0]   tx_addr_q, tx_addr_d;
  logic [1:0]          tx_cl_len_q, tx_cl_len_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;

  logic                in_burst, work_left, can_burst, can_single, issue_window;
  logic                sop, burst_beat, beat;
  logic [LEN_W-1:0]    remaining, sop_len, rsp_lines, ack_room, ack_apply, out_inc;

  assign in_burst     = (burst_left_q != 2'd0);
  assign work_left    = (issued_q != num_lines_q);
  assign remaining    = num_lines_q - issued_q;
  assign can_burst    = (BURST_LINES > 1) && ((next_addr_q & ALIGN_MASK) == '0) &&
                        (remaining >= BURST_LEN) && (buf_count >= BURST_BUF) &&
                        (outstanding_q + BURST_LEN <= MAX_OUT);
  assign can_single   = (buf_count != '0) && (outstanding_q < MAX_OUT);
  assign issue_window = reset && (state_q == ISSUE) && !in_burst && work_left;
  assign sop          = issue_window && !tx_almfull && (can_burst || can_single);
  // Beats after the SOP never re-check almfull or buffer level: both were committed at SOP.
  assign burst_beat   = reset && (state_q == ISSUE) && in_burst;
  assign beat         = sop || burst_beat;
  assign sop_len      = can_burst ? BURST_LEN : LEN_W'(1);
  assign rsp_lines    = rx_wr_rsp_packed ? (LEN_W'(rx_wr_rsp_cl_num) + LEN_W'(1)) : LEN_W'(1);
  assign ack_room     = num_lines_q - acked_q;
  assign out_inc      = outstanding_q + (sop ? sop_len : '0);

  assign buf_rd_en = beat;
  assign done      = (state_q == IDLE);
  assign err_rsp   = err_q;
  assign tx_valid  = tx_valid_q;
  assign tx_sop    = tx_sop_q;
  assign tx_addr   = tx_addr_q;
  assign tx_cl_len = tx_cl_len_q;
  assign tx_data   = tx_data_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d       = state_q;
    next_addr_d   = next_addr_q;
    burst_addr_d  = burst_addr_q;
    num_lines_d   = num_lines_q;
    issued_d      = issued_q;
    acked_d       = acked_q;
    burst_left_d  = burst_left_q;
    burst_cl_d    = burst_cl_q;
    err_d         = err_q;
    tx_valid_d    = beat;
    tx_sop_d      = sop;
    tx_addr_d     = tx_addr_q;
    tx_cl_len_d   = tx_cl_len_q;
    tx_data_d     = tx_data_q;
    ack_apply     = '0;

    // Excess acknowledgements saturate at num_lines and flag the error.
    if (rx_wr_rsp_valid) begin
      if (state_q == IDLE) begin
        err_d = 1'b1;
      end else begin
        if (rsp_lines > ack_room) begin
          ack_apply = ack_room;
          err_d     = 1'b1;
        end else begin
          ack_apply = rsp_lines;
        end
        acked_d = acked_q + ack_apply;
      end
    end
    outstanding_d = (out_inc > ack_apply) ? (out_inc - ack_apply) : '0;

    if (sop) begin
      next_addr_d  = next_addr_q + (can_burst ? ADDR_W'(BURST_LINES) : ADDR_W'(1));
      burst_addr_d = next_addr_q;
      burst_left_d = can_burst ? BURST_CL : 2'd0;
      burst_cl_d   = can_burst ? BURST_CL : 2'd0;
      tx_addr_d    = next_addr_q;
      tx_cl_len_d  = can_burst ? BURST_CL : 2'd0;
    end else if (burst_beat) begin
      burst_left_d = burst_left_q - 2'd1;
      tx_addr_d    = burst_addr_q;
      tx_cl_len_d  = burst_cl_q;
    end
    if (beat) begin
      issued_d  = issued_q + LEN_W'(1);
      tx_data_d = buf_rd_data;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          num_lines_d   = num_lines;
          next_addr_d   = base_addr;
          issued_d      = '0;
          acked_d       = '0;
          outstanding_d = '0;
          burst_left_d  = 2'd0;
          err_d         = 1'b0;
          if (num_lines != '0) state_d = ISSUE;
        end
      end
      ISSUE: if (!in_burst && !work_left) state_d = DRAIN;
      DRAIN: if (acked_q == num_lines_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      next_addr_q   <= '0;
      burst_addr_q  <= '0;
      num_lines_q   <= '0;
      issued_q      <= '0;
      acked_q       <= '0;
      outstanding_q <= '0;
      burst_left_q  <= 2'd0;
      burst_cl_q    <= 2'd0;
      err_q         <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_sop_q      <= 1'b0;
      tx_addr_q     <= '0;
      tx_cl_len_q   <= 2'd0;
      tx_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      next_addr_q   <= next_addr_d;
      burst_addr_q  <= burst_addr_d;
      num_lines_q   <= num_lines_d;
      issued_q      <= issued_d;
      acked_q       <= acked_d;
      outstanding_q <= outstanding_d;
      burst_left_q  <= burst_left_d;
      burst_cl_q    <= burst_cl_d;
      err_q         <= err_d;
      tx_valid_q    <= tx_valid_d;
      tx_sop_q      <= tx_sop_d;
      tx_addr_q     <= tx_addr_d;
      tx_cl_len_q   <= tx_cl_len_d;
      tx_data_q     <= tx_data_d;
    end
  end

`ifdef WR_ENGINE_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_almfull_q, perf_almfull_d;
  logic [31:0] perf_credit_q, perf_credit_d;
  logic [31:0] perf_empty_q, perf_empty_d;
  logic        stall;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Stall cause priority: almfull, then credit (even a single line would exceed it), then empty.
  assign stall = issue_window && !sop;

  always_comb begin
    perf_cycles_d  = perf_cycles_q;
    perf_almfull_d = perf_almfull_q;
    perf_credit_d  = perf_credit_q;
    perf_empty_d   = perf_empty_q;
    if (state_q == IDLE && start) begin
      perf_cycles_d  = '0;
      perf_almfull_d = '0;
      perf_credit_d  = '0;
      perf_empty_d   = '0;
    end else begin
      if (state_q != IDLE) perf_cycles_d = sat_inc(perf_cycles_q);
      if (stall) begin
        if (tx_almfull)                    perf_almfull_d = sat_inc(perf_almfull_q);
        else if (outstanding_q >= MAX_OUT) perf_credit_d  = sat_inc(perf_credit_q);
        else                               perf_empty_d   = sat_inc(perf_empty_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_cycles_q  <= '0;
      perf_almfull_q <= '0;
      perf_credit_q  <= '0;
      perf_empty_q   <= '0;
    end else begin
      perf_cycles_q  <= perf_cycles_d;
      perf_almfull_q <= perf_almfull_d;
      perf_credit_q  <= perf_credit_d;
      perf_empty_q   <= perf_empty_d;
    end
  end

  assign perf_cycles        = perf_cycles_q;
  assign perf_stall_almfull = perf_almfull_q;
  assign perf_stall_credit  = perf_credit_q;
  assign perf_stall_empty   = perf_empty_q;
`endif

endmodule

// File: tb/tb_buffer_to_mem_wr_engine.sv
// Directed bench for buffer_to_mem_wr_engine: a scoreboard queue of expected write beats checked by a
// monitor, plus directed checks on done, err_rsp, pop counts and credit/almfull stalls.
module tb_buffer_to_mem_wr_engine;
  localparam int ADDR_W    = 42;
  localparam int LEN_W     = 32;
  localparam int DATA_W    = 64;
  localparam int BURST     = 4;
  localparam int MAX_OUT   = 4;
  localparam int BUF_CNT_W = 8;
  localparam int EXP_W     = 1 + 2 + ADDR_W + DATA_W;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [ADDR_W-1:0]    base_addr;
  logic [LEN_W-1:0]     num_lines;
  logic                 done;
  logic                 err_rsp;
  logic [DATA_W-1:0]    buf_rd_data;
  logic [BUF_CNT_W-1:0] buf_count;
  logic                 buf_rd_en;
  logic                 tx_almfull;
  logic                 tx_valid;
  logic                 tx_sop;
  logic [ADDR_W-1:0]    tx_addr;
  logic [1:0]           tx_cl_len;
  logic [DATA_W-1:0]    tx_data;
  logic                 rx_wr_rsp_valid;
  logic                 rx_wr_rsp_packed;
  logic [1:0]           rx_wr_rsp_cl_num;
  logic [1:0]           dbg_state;

  buffer_to_mem_wr_engine #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .BURST_LINES(BURST),
    .MAX_OUTSTANDING(MAX_OUT), .BUF_CNT_W(BUF_CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .done(done), .err_rsp(err_rsp), .buf_rd_data(buf_rd_data), .buf_count(buf_count),
    .buf_rd_en(buf_rd_en), .tx_almfull(tx_almfull), .tx_valid(tx_valid), .tx_sop(tx_sop),
    .tx_addr(tx_addr), .tx_cl_len(tx_cl_len), .tx_data(tx_data),
    .rx_wr_rsp_valid(rx_wr_rsp_valid), .rx_wr_rsp_packed(rx_wr_rsp_packed),
    .rx_wr_rsp_cl_num(rx_wr_rsp_cl_num), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int beat_cnt = 0;
  int pops = 0;
  logic pop_seen = 1'b0;
  logic [DATA_W-1:0] buf_q[$];
  logic [EXP_W-1:0]  exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- FWFT buffer model ----------------
  always @(posedge clk) begin
    pop_seen <= buf_rd_en;
    if (buf_rd_en) pops <= pops + 1;
  end

  always @(negedge clk) begin
    if (pop_seen && buf_q.size() > 0) void'(buf_q.pop_front());
    buf_count   = (buf_q.size() > 255) ? 8'd255 : BUF_CNT_W'(buf_q.size());
    buf_rd_data = (buf_q.size() > 0) ? buf_q[0] : '0;
  end

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #1;
    if (tx_valid) begin
      beat_cnt++;
      if (exp_q.size() == 0) check("beat_unexpected", 128'(tx_addr), 128'(0));
      else check("beat", 128'({tx_sop, tx_cl_len, tx_addr, tx_data}), 128'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int n, input logic [DATA_W-1:0] seed);
    for (int i = 0; i < n; i++) buf_q.push_back(seed + DATA_W'(i));
    cycles(2);
  endtask

  task automatic push_beat(input logic sop, input logic [1:0] cl, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    exp_q.push_back({sop, cl, a, d});
  endtask

  task automatic push_burst(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d0);
    for (int i = 0; i < 4; i++) push_beat(i == 0, 2'd3, a, d0 + DATA_W'(i));
  endtask

  task automatic start_run(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n);
    @(negedge clk);
    start = 1'b1; base_addr = a; num_lines = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_rsp(input logic packed_rsp, input logic [1:0] cl);
    @(negedge clk);
    rx_wr_rsp_valid = 1'b1; rx_wr_rsp_packed = packed_rsp; rx_wr_rsp_cl_num = cl;
    @(negedge clk);
    rx_wr_rsp_valid = 1'b0; rx_wr_rsp_packed = 1'b0; rx_wr_rsp_cl_num = 2'd0;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k = 0;
    while (beat_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("beats_reached", 128'(beat_cnt >= target), 128'(1));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_rise", 128'(done), 128'(1));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int b0, p0;
    reset = 1'b0; start = 1'b0; base_addr = '0; num_lines = '0; tx_almfull = 1'b0;
    rx_wr_rsp_valid = 1'b0; rx_wr_rsp_packed = 1'b0; rx_wr_rsp_cl_num = 2'd0;
    buf_count = '0; buf_rd_data = '0;
    cycles(3);
    check("rst_done", 128'(done), 128'(1));
    check("rst_err", 128'(err_rsp), 128'(0));
    check("rst_tx_valid", 128'(tx_valid), 128'(0));
    check("rst_tx_fields", 128'({tx_sop, tx_cl_len, tx_addr, tx_data}), 128'(0));
    reset = 1'b1;
    cycles(2);

    // Aligned 8-line run: two 4-line bursts; credit of 4 holds the second until a packed ack.
    load(8, 64'hA0);
    push_burst(42'h100, 64'hA0);
    push_burst(42'h104, 64'hA4);
    b0 = beat_cnt; p0 = pops;
    start_run(42'h100, 8);
    wait_beats(b0 + 4, 50);
    cycles(5);
    check("t1_credit_hold", 128'(beat_cnt - b0), 128'(4));
    send_rsp(1'b1, 2'd3);
    wait_beats(b0 + 8, 50);
    check("t1_not_done", 128'(done), 128'(0));
    send_rsp(1'b1, 2'd3);
    wait_done(20);
    check("t1_pops", 128'(pops - p0), 128'(8));
    check("t1_err", 128'(err_rsp), 128'(0));

    // Unaligned base: all single-line requests 0x101..0x105.
    load(5, 64'hB0);
    for (int i = 0; i < 5; i++) push_beat(1'b1, 2'd0, 42'h101 + 42'(i), 64'hB0 + 64'(i));
    b0 = beat_cnt; p0 = pops;
    start_run(42'h101, 5);
    wait_beats(b0 + 4, 50);
    cycles(3);
    check("t2_credit_hold", 128'(beat_cnt - b0), 128'(4));
    repeat (4) send_rsp(1'b0, 2'd0);
    wait_beats(b0 + 5, 50);
    send_rsp(1'b0, 2'd0);
    wait_done(20);
    check("t2_pops", 128'(pops - p0), 128'(5));

    // Credit limit with responses withheld.
    load(12, 64'hC0);
    push_burst(42'h200, 64'hC0);
    push_burst(42'h204, 64'hC4);
    push_burst(42'h208, 64'hC8);
    b0 = beat_cnt;
    start_run(42'h200, 12);
    cycles(20);
    check("t3_stall4", 128'(beat_cnt - b0), 128'(4));
    send_rsp(1'b1, 2'd3);
    cycles(20);
    check("t3_stall8", 128'(beat_cnt - b0), 128'(8));
    send_rsp(1'b1, 2'd3);
    wait_beats(b0 + 12, 50);
    send_rsp(1'b1, 2'd3);
    wait_done(20);

    // Almfull raised during the second beat: burst completes, next SOP waits.
    load(8, 64'hD0);
    push_burst(42'h300, 64'hD0);
    push_burst(42'h304, 64'hD4);
    b0 = beat_cnt;
    start_run(42'h300, 8);
    wait_beats(b0 + 1, 50);
    tx_almfull = 1'b1;
    cycles(8);
    check("t4_burst_done", 128'(beat_cnt - b0), 128'(4));
    send_rsp(1'b1, 2'd3);
    cycles(8);
    check("t4_almfull_hold", 128'(beat_cnt - b0), 128'(4));
    tx_almfull = 1'b0;
    wait_beats(b0 + 8, 50);
    send_rsp(1'b1, 2'd3);
    wait_done(20);

    // Response in IDLE sets sticky err; start clears; excess ack saturates and sets err.
    send_rsp(1'b0, 2'd0);
    cycles(2);
    check("t5_err_idle", 128'(err_rsp), 128'(1));
    cycles(5);
    check("t5_err_held", 128'(err_rsp), 128'(1));
    load(8, 64'hE0);
    push_burst(42'h400, 64'hE0);
    push_burst(42'h404, 64'hE4);
    b0 = beat_cnt;
    start_run(42'h400, 8);
    check("t5_err_clr", 128'(err_rsp), 128'(0));
    wait_beats(b0 + 4, 50);
    send_rsp(1'b1, 2'd3);
    wait_beats(b0 + 8, 50);
    send_rsp(1'b0, 2'd0);
    check("t5_err_ok", 128'(err_rsp), 128'(0));
    send_rsp(1'b1, 2'd3);
    check("t5_err_excess", 128'(err_rsp), 128'(1));
    wait_done(20);
    cycles(3);
    check("t5_err_sticky", 128'(err_rsp), 128'(1));

    // Zero-length start stays idle with no beats.
    b0 = beat_cnt;
    start_run(42'h700, 0);
    check("t6_zero_done", 128'(done), 128'(1));
    cycles(5);
    check("t6_zero_done_hold", 128'(done), 128'(1));
    check("t6_zero_nobeats", 128'(beat_cnt - b0), 128'(0));

    // Reset mid-burst aborts; a following 1-line run writes exactly one line.
    load(4, 64'hF0);
    push_beat(1'b1, 2'd3, 42'h500, 64'hF0);
    b0 = beat_cnt;
    start_run(42'h500, 4);
    wait_beats(b0 + 1, 50);
    reset = 1'b0;
    @(negedge clk);
    check("t7_rst_valid", 128'(tx_valid), 128'(0));
    check("t7_rst_done", 128'(done), 128'(1));
    reset = 1'b1;
    buf_q.delete();
    cycles(3);
    check("t7_aborted_beats", 128'(beat_cnt - b0), 128'(1));
    check("t7_err_after_rst", 128'(err_rsp), 128'(0));
    load(1, 64'hF8);
    push_beat(1'b1, 2'd0, 42'h600, 64'hF8);
    b0 = beat_cnt; p0 = pops;
    start_run(42'h600, 1);
    wait_beats(b0 + 1, 50);
    cycles(5);
    check("t7_one_beat", 128'(beat_cnt - b0), 128'(1));
    check("t7_one_pop", 128'(pops - p0), 128'(1));
    send_rsp(1'b0, 2'd0);
    wait_done(20);

    cycles(3);
    check("exp_q_empty", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/buffer_to_mem_wr_engine.md
Name: buffer_to_mem_wr_engine

Overview:
Parametrised successor of the single-line buffer-to-memory write state machine. Drains a first-word-fall-through line buffer into host memory as CCI-P write requests, using multi-line bursts where legal. It enforces an outstanding-write credit limit, accounts for packed and unpacked write responses, and signals completion only when every line is acknowledged. It sits between the accelerator result buffer and the MPF C1 TX/RX channels.

Parameters:
ADDR_W, 42, cache-line address width
LEN_W, 32, width of line-count input
DATA_W, 512, line width
BURST_LINES, 4, maximum lines per request; legal values are 1, 2 or 4
MAX_OUTSTANDING, 64, maximum unacknowledged lines in flight
BUF_CNT_W, 8, width of buffer occupancy input

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
start  in  1  one-cycle pulse; latches base_addr and num_lines
base_addr  in  ADDR_W  first cache-line address
num_lines  in  LEN_W  number of lines to write
done  out  1  high in IDLE
err_rsp  out  1  sticky flag: unexpected or excess write response
buf_rd_data  in  DATA_W  head of FWFT buffer
buf_count  in  BUF_CNT_W  lines available in buffer
buf_rd_en  out  1  pop buffer head (combinational)
tx_almfull  in  1  C1 TX almost full
tx_valid  out  1  write beat valid
tx_sop  out  1  first beat of a request
tx_addr  out  ADDR_W  burst base address (same on every beat)
tx_cl_len  out  2  lines in request minus 1 (0, 1 or 3)
tx_data  out  DATA_W  beat data
rx_wr_rsp_valid  in  1  write response
rx_wr_rsp_packed  in  1  response covers a whole burst
rx_wr_rsp_cl_num  in  2  lines covered minus 1, used when packed

Behaviour:
- Reset values: done=1; err_rsp=0; tx_valid=0; tx_sop=0; tx_addr=0; tx_cl_len=0; tx_data=0. All counters are 0 and the state is IDLE. Reset mid-operation aborts immediately; no further beats are issued.
- States:
  - IDLE: on start with num_lines!=0, go to ISSUE. start with num_lines==0 stays in IDLE; done stays 1. start outside IDLE is ignored.
  - ISSUE: leave for DRAIN when issued==num_lines and no burst is in progress.
  - DRAIN: go to IDLE in the cycle after acked==num_lines.
- Start of request (SOP) decision, evaluated in ISSUE when no burst is in progress and tx_almfull=0:
  - Use L=BURST_LINES if BURST_LINES>1, next_addr%BURST_LINES==0, remaining>=BURST_LINES, buf_count>=BURST_LINES and outstanding+BURST_LINES<=MAX_OUTSTANDING.
  - Otherwise use L=1 if buf_count>=1 and outstanding<MAX_OUTSTANDING.
  - Otherwise stall.
- Beats of a started burst issue on consecutive cycles regardless of tx_almfull. buf_count>=L at SOP guarantees data.
- buf_rd_en is high in every cycle a beat issues. tx_valid, tx_sop, tx_addr, tx_cl_len and tx_data are registered, so latency from pop to tx_valid is 1 cycle.
- next_addr advances by L at SOP and wraps modulo 2^ADDR_W. issued advances by 1 per beat.
- outstanding increases by L at SOP and decreases by the lines acknowledged per response. Increase and decrease in the same cycle apply both.
- Lines acknowledged per response: rx_wr_rsp_cl_num+1 if packed, else 1. acked accumulates them.
- Responses received in IDLE are ignored for counting and set err_rsp. A response that would push acked above num_lines saturates acked at num_lines and sets err_rsp.
- err_rsp clears only on reset or on an accepted start.

Optional Feature:
WR_ENGINE_PERF_EN: adds outputs perf_cycles[31:0], perf_stall_almfull[31:0], perf_stall_credit[31:0] and perf_stall_empty[31:0].
- All four clear on accepted start.
- perf_cycles counts cycles not in IDLE.
- Each stall counter increments in an ISSUE cycle with no beat, attributed to the first blocking cause in the order almfull, credit, empty.
- All four saturate at all-ones.
Without the macro these ports and their logic are absent.

Test Plan:
- base=0x100, num_lines=8, buffer full, BURST_LINES=4, packed responses (cl_num=3) -> two 4-beat requests at 0x100 and 0x104; done rises after the 2nd response; 8 pops total.
- base=0x101, num_lines=5 -> 1-line requests at 0x101, 0x102, 0x103, then one 2-line... no: with BURST_LINES=4, expect 1-line requests at 0x101-0x103, then remaining=2 gives two 1-line requests at 0x104 and 0x105.
- MAX_OUTSTANDING=4, num_lines=12, responses withheld -> exactly 4 beats issued, then stall; releasing one packed response of 4 resumes issue.
- tx_almfull asserted during the second beat of a burst -> burst completes its 4 beats; the next SOP waits until tx_almfull=0.
- Response while IDLE, or 9th line acknowledged when num_lines=8 -> err_rsp=1, held until the next start.
- Reset asserted mid-burst -> tx_valid=0, done=1 the cycle after; a subsequent start with num_lines=1 writes exactly 1 line.
